// File: rtl/scan_mux_n1_if.sv
// -----------------------------------------------------------------------------
// scan_mux_n1_if
//   Bundles the channel inputs, select controls and the valid/ready output
//   stage of scan_mux_n1. The producer side, a bench or the upstream logic,
//   uses the master modport. The mux itself uses the slave modport.
//
//   Parameters : NCH (channels), DW (data width per channel)
//   Signals    : mode, sel[SW], ch_en[NCH], din[NCH*DW], out_ready  -> to mux
//                out_valid, dout[DW], out_ch[SW] (+ out_par)       <- from mux
//   Build macro: SCAN_MUX_PARITY_EN adds out_par (even parity of dout).
// -----------------------------------------------------------------------------
interface scan_mux_n1_if #(
    parameter int NCH = 8,
    parameter int DW  = 8
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              mode;
    logic [SW-1:0]     sel;
    logic [NCH-1:0]    ch_en;
    logic [NCH*DW-1:0] din;
    logic              out_ready;
    logic              out_valid;
    logic [DW-1:0]     dout;
    logic [SW-1:0]     out_ch;
`ifdef SCAN_MUX_PARITY_EN
    logic              out_par;
`endif

    modport master (
        output mode, sel, ch_en, din, out_ready,
        input  out_valid, dout, out_ch
`ifdef SCAN_MUX_PARITY_EN
        , input out_par
`endif
    );

    modport slave (
        input  mode, sel, ch_en, din, out_ready,
        output out_valid, dout, out_ch
`ifdef SCAN_MUX_PARITY_EN
        , output out_par
`endif
    );
endinterface

// File: rtl/scan_mux_n1.sv
// -----------------------------------------------------------------------------
// scan_mux_n1
//   This is a parametrised N:1 registered multiplexer with a single valid/ready
//   output register and no skid buffer. It has two ways to choose a channel.
//     mode=0 : the channel is the one named by sel. It is used only when
//              sel < NCH and ch_en[sel] is set.
//     mode=1 : the channel comes from a round-robin scan over the enabled
//              channels. The scan starts at an internal pointer.
//   The output register is loaded when it is empty or when the consumer takes
//   the current sample. While stalled, all state holds.
//
//   Ports
//     clk  : rising-edge clock
//     rst  : asynchronous active-high reset
//     bus  : scan_mux_n1_if.slave
//            inputs  : mode, sel, ch_en, din, out_ready
//            outputs : out_valid, dout, out_ch
//   Build macro
//     SCAN_MUX_PARITY_EN : drives bus.out_par with the even parity of dout.
//                          The parity bit is registered together with dout.
//   The interface instance must use the same NCH/DW as this module.
// -----------------------------------------------------------------------------
module scan_mux_n1 #(
    parameter int NCH = 8,
    parameter int DW  = 8
) (
    input  logic clk,
    input  logic rst,
    scan_mux_n1_if.slave bus
);
    localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NPAD = 1 << SW;

    // The data and enable tables are padded up to a power of two. An
    // out-of-range direct select then reads a disabled padding entry, so no
    // separate range compare is needed.
    logic [DW-1:0]   ch_data [NPAD];
    logic [NPAD-1:0] en_pad;

    generate
        for (genvar gi = 0; gi < NPAD; gi++) begin : g_ch
            if (gi < NCH) begin : g_real
                assign ch_data[gi] = bus.din[gi*DW +: DW];
                assign en_pad[gi]  = bus.ch_en[gi];
            end else begin : g_pad
                assign ch_data[gi] = '0;
                assign en_pad[gi]  = 1'b0;
            end
        end
    endgenerate

    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] dout_q, dout_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic [SW-1:0] ptr_q, ptr_d;
    logic          mode_q;

    logic          ld;
    logic [SW-1:0] scan_start;
    logic [SW-1:0] scan_tgt;
    logic          scan_found;
    logic [SW-1:0] tgt;
    logic          found;

    // On the cycle that scan mode is entered, the search restarts from channel 0.
    assign scan_start = (bus.mode && !mode_q) ? '0 : ptr_q;

    // This is a circular priority search beginning at scan_start. The loop runs
    // from the farthest offset down to the nearest one. The nearest enabled
    // channel is assigned last, so it wins. A disabled channel under the
    // pointer is skipped in the same cycle.
    always_comb begin : scan_search
        int idx;
        idx        = 0;
        scan_found = 1'b0;
        scan_tgt   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(scan_start) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (bus.ch_en[idx]) begin
                scan_found = 1'b1;
                scan_tgt   = SW'(idx);
            end
        end
    end

    always_comb begin : next_state
        ld          = !out_valid_q || bus.out_ready;
        tgt         = bus.mode ? scan_tgt : bus.sel;
        found       = bus.mode ? scan_found : en_pad[bus.sel];
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (ld) begin
            if (found) begin
                out_valid_d = 1'b1;
                dout_d      = ch_data[tgt];
                out_ch_d    = tgt;
                if (bus.mode) begin
                    ptr_d = (tgt == SW'(NCH - 1)) ? '0 : tgt + 1'b1;
                end
            end else begin
                // No channel qualifies. The output goes empty, and the last
                // data and channel values remain visible.
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
            mode_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
            mode_q      <= bus.mode;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.out_ch    = out_ch_q;

`ifdef SCAN_MUX_PARITY_EN
    // The parity bit follows dout_d. It therefore holds whenever dout holds.
    logic par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^dout_d;
        end
    end
    assign bus.out_par = par_q;
`endif

endmodule

// File: tb/tb_scan_mux_n1.sv
// -----------------------------------------------------------------------------
// tb_scan_mux_n1
//   This is a directed, table-driven bench for scan_mux_n1 with NCH=8 and DW=8.
//   Hand-written sequences cover asynchronous reset during a stall. A second
//   instance with NCH=6 covers out-of-range select and pointer wrap.
// -----------------------------------------------------------------------------
module tb_scan_mux_n1;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    scan_mux_n1_if #(.NCH(8), .DW(8)) bus  ();
    scan_mux_n1_if #(.NCH(6), .DW(8)) bus6 ();

    scan_mux_n1 #(.NCH(8), .DW(8)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    scan_mux_n1 #(.NCH(6), .DW(8)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [2:0] sel;
        logic [7:0] en;
        logic       rdy;
        logic [7:0] dbase;   // din[i] = dbase + i
        logic       ev;
        logic [7:0] ed;
        logic [2:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic m, input logic [2:0] s, input logic [7:0] en,
                       input logic r, input logic [7:0] db,
                       input logic ev, input logic [7:0] ed, input logic [2:0] ec);
        vec_t v;
        v.mode = m; v.sel = s; v.en = en; v.rdy = r; v.dbase = db;
        v.ev = ev; v.ed = ed; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_din(input logic [7:0] base);
        for (int i = 0; i < 8; i++) begin
            bus.din[i*8 +: 8] = base + 8'(i);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [7:0] ed,
                             input logic [2:0] ec);
        $display("%s: valid=%0d dout=%0h ch=%0d", tag, bus.out_valid, bus.dout, bus.out_ch);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(ev));
        check({tag, "_dout"},  64'(bus.dout),      64'(ed));
        check({tag, "_ch"},    64'(bus.out_ch),    64'(ec));
`ifdef SCAN_MUX_PARITY_EN
        check({tag, "_par"},   64'(bus.out_par),   64'(^ed));
`endif
    endtask

    task automatic check_out6(input string tag, input logic ev, input logic [7:0] ed,
                              input logic [2:0] ec);
        $display("%s: valid=%0d dout=%0h ch=%0d", tag, bus6.out_valid, bus6.dout, bus6.out_ch);
        check({tag, "_valid"}, 64'(bus6.out_valid), 64'(ev));
        check({tag, "_dout"},  64'(bus6.dout),      64'(ed));
        check({tag, "_ch"},    64'(bus6.out_ch),    64'(ec));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.mode = 1'b0; bus.sel = 3'd0; bus.ch_en = 8'h00; bus.out_ready = 1'b1;
        set_din(8'hA0);
        bus6.mode = 1'b0; bus6.sel = 3'd0; bus6.ch_en = 6'h00; bus6.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) bus6.din[i*8 +: 8] = 8'hA0 + 8'(i);

        //   mode sel    en        rdy   dbase  ev    ed     ec
        add(1'b0, 3'd5, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA5, 3'd5); // direct, sel 5
        add(1'b0, 3'd3, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA3, 3'd3);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA0, 3'd0); // scan 0,2,5,7,0,2
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA2, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA5, 3'd5);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA7, 3'd7);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA0, 3'd0);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA2, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b0, 8'h50, 1'b1, 8'hA2, 3'd2); // stall 4 clks, din moving
        add(1'b1, 3'd0, 8'hA5, 1'b0, 8'h60, 1'b1, 8'hA2, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b0, 8'h70, 1'b1, 8'hA2, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b0, 8'h80, 1'b1, 8'hA2, 3'd2);
        add(1'b1, 3'd0, 8'hA5, 1'b1, 8'hA0, 1'b1, 8'hA5, 3'd5); // resumes after held ch
        add(1'b1, 3'd0, 8'h01, 1'b1, 8'hA0, 1'b1, 8'hA0, 3'd0); // ptr 6 -> skip to 0
        add(1'b1, 3'd0, 8'h00, 1'b1, 8'hA0, 1'b0, 8'hA0, 3'd0); // nothing enabled
        add(1'b1, 3'd0, 8'h00, 1'b1, 8'hA0, 1'b0, 8'hA0, 3'd0);
        add(1'b0, 3'd3, 8'hF7, 1'b1, 8'hA0, 1'b0, 8'hA0, 3'd0); // sel 3 disabled
        add(1'b0, 3'd3, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA3, 3'd3);
        add(1'b0, 3'd3, 8'hF7, 1'b0, 8'h50, 1'b1, 8'hA3, 3'd3); // stalled, en change ignored
        add(1'b0, 3'd3, 8'hF7, 1'b1, 8'hA0, 1'b0, 8'hA3, 3'd3); // accepted, then drop
        add(1'b1, 3'd0, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA0, 3'd0); // scan up to ptr 6
        add(1'b1, 3'd0, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA1, 3'd1);
        add(1'b1, 3'd0, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA2, 3'd2);
        add(1'b1, 3'd0, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA3, 3'd3);
        add(1'b1, 3'd0, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA4, 3'd4);
        add(1'b1, 3'd0, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA5, 3'd5);
        add(1'b0, 3'd2, 8'hFF, 1'b1, 8'hA0, 1'b1, 8'hA2, 3'd2); // direct interlude
        add(1'b1, 3'd0, 8'h4A, 1'b1, 8'hA0, 1'b1, 8'hA1, 3'd1); // re-entry restarts at 0
        add(1'b1, 3'd0, 8'h4A, 1'b1, 8'hA0, 1'b1, 8'hA3, 3'd3);
        add(1'b1, 3'd0, 8'h4A, 1'b1, 8'hA0, 1'b1, 8'hA6, 3'd6);
        add(1'b1, 3'd0, 8'h4A, 1'b1, 8'hA0, 1'b1, 8'hA1, 3'd1);

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out("reset", 1'b0, 8'h00, 3'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            bus.mode = tbl[i].mode; bus.sel = tbl[i].sel; bus.ch_en = tbl[i].en;
            bus.out_ready = tbl[i].rdy;
            set_din(tbl[i].dbase);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec);
        end

        // Asynchronous reset while a sample is held under backpressure
        @(negedge clk);
        bus.mode = 1'b0; bus.sel = 3'd5; bus.ch_en = 8'hFF; bus.out_ready = 1'b0;
        set_din(8'hA0);
        @(posedge clk);
        #1;
        check_out("stall_hold", 1'b1, 8'hA1, 3'd1);
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 8'h00, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_rst", 1'b1, 8'hA5, 3'd5);
        @(posedge clk);
        #1;
        check_out("post_rst_hold", 1'b1, 8'hA5, 3'd5);

        // NCH=6 instance: out-of-range select and pointer wrap at NCH-1
        @(negedge clk);
        bus6.sel = 3'd5; bus6.ch_en = 6'h3F;
        @(posedge clk); #1;
        check_out6("n6_sel5", 1'b1, 8'hA5, 3'd5);
        @(negedge clk);
        bus6.sel = 3'd7;
        @(posedge clk); #1;
        check_out6("n6_sel7", 1'b0, 8'hA5, 3'd5);
        @(negedge clk);
        bus6.sel = 3'd6;
        @(posedge clk); #1;
        check_out6("n6_sel6", 1'b0, 8'hA5, 3'd5);
        @(negedge clk);
        bus6.mode = 1'b1; bus6.ch_en = 6'h20;
        @(posedge clk); #1;
        check_out6("n6_scan5", 1'b1, 8'hA5, 3'd5);
        @(negedge clk);
        bus6.ch_en = 6'h21;
        @(posedge clk); #1;
        check_out6("n6_wrap0", 1'b1, 8'hA0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
